// File: rtl/mixer_ctrl_pkg.sv
// rtl/mixer_ctrl_pkg.sv - shared constants and state encoding for the output mixer controller
package mixer_ctrl_pkg;
  localparam logic [1:0] ADDR_NR50 = 2'd0;
  localparam logic [1:0] ADDR_NR51 = 2'd1;
  localparam logic [1:0] ADDR_NR52 = 2'd2;

  localparam logic [2:0] NR52_PAD = 3'b111;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ON       = 2'd1,
    ST_FADE_OUT = 2'd2
  } state_t;
endpackage

// File: rtl/mixer_ctrl_if.sv
// rtl/mixer_ctrl_if.sv - CPU register bus and mixer drive signals of the mixer controller
interface mixer_ctrl_if;
  logic       wr_en;
  logic       rd_en;
  logic [1:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [3:0] ch_on;
  logic [3:0] enL;
  logic [3:0] enR;
  logic [2:0] volL;
  logic [2:0] volR;
  logic       busy;

  modport master (
    output wr_en, rd_en, addr, wr_data, ch_on,
    input  rd_data, enL, enR, volL, volR, busy
  );

  modport slave (
    input  wr_en, rd_en, addr, wr_data, ch_on,
    output rd_data, enL, enR, volL, volR, busy
  );
endinterface

// File: rtl/mixer_ctrl_vol_ramp.sv
// rtl/mixer_ctrl_vol_ramp.sv - 3-bit volume stepper, moves one step toward target per tick
module vol_ramp (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_hold,
  input  logic [2:0] i_tgt,
  output logic [2:0] o_cur
);
  logic [2:0] r_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur <= 3'd0;
    end else if (i_hold) begin
      r_cur <= 3'd0;
    end else if (i_tick) begin
      if (r_cur < i_tgt) begin
        r_cur <= r_cur + 3'd1;
      end else if (r_cur > i_tgt) begin
        r_cur <= r_cur - 3'd1;
      end
    end
  end

  assign o_cur = r_cur;
endmodule

// File: rtl/mixer_ctrl.sv
// rtl/mixer_ctrl.sv - NR50/NR51/NR52 register front-end with volume ramp and fade-out sequencer
module mixer_ctrl
  import mixer_ctrl_pkg::*;
#(
  parameter int RAMP_DIV = 64,
  parameter int PW       = 7
) (
  input  logic        clk,
  input  logic        rst,
  mixer_ctrl_if.slave bus
);
  localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_nr50, r_nr51, r_rd_data, w_rd_mux;
  logic          r_power;
  logic [PW-1:0] r_presc;
  logic          w_tick, w_wr_nr50, w_wr_nr51, w_power_on, w_enter_off, w_hold;
  logic [2:0]    w_tgt_l, w_tgt_r, w_cur_l, w_cur_r;

  assign w_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nr50   = 1'b0;
    w_wr_nr51   = 1'b0;
    w_power_on  = 1'b0;
    w_enter_off = 1'b0;
    w_hold      = 1'b0;
    w_tgt_l     = 3'd0;
    w_tgt_r     = 3'd0;
    case (r_state)
      ST_OFF: begin
        w_hold = 1'b1;
        if (bus.wr_en && bus.addr == ADDR_NR52 && bus.wr_data[7]) begin
          w_state_nxt = ST_ON;
          w_power_on  = 1'b1;
        end
      end
      ST_ON: begin
        w_tgt_l   = r_nr50[6:4];
        w_tgt_r   = r_nr50[2:0];
        w_wr_nr50 = bus.wr_en && (bus.addr == ADDR_NR50);
        w_wr_nr51 = bus.wr_en && (bus.addr == ADDR_NR51);
        if (bus.wr_en && bus.addr == ADDR_NR52 && !bus.wr_data[7]) begin
          w_state_nxt = ST_FADE_OUT;
        end
      end
      ST_FADE_OUT: begin
        // Decision uses pre-tick volumes; ramp has nothing left to do at 0/0.
        if (w_tick && w_cur_l == 3'd0 && w_cur_r == 3'd0) begin
          w_state_nxt = ST_OFF;
          w_enter_off = 1'b1;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nr50  <= 8'h00;
      r_nr51  <= 8'h00;
      r_power <= 1'b0;
    end else if (w_enter_off) begin
      r_nr50  <= 8'h00;
      r_nr51  <= 8'h00;
      r_power <= 1'b0;
    end else begin
      if (w_wr_nr50) r_nr50 <= bus.wr_data;
      if (w_wr_nr51) r_nr51 <= bus.wr_data;
      if (w_power_on) r_power <= 1'b1;
    end
  end

  always_comb begin
    w_rd_mux = 8'hFF;
    case (bus.addr)
      ADDR_NR50: w_rd_mux = r_nr50;
      ADDR_NR51: w_rd_mux = r_nr51;
      ADDR_NR52: w_rd_mux = {r_power, NR52_PAD, bus.ch_on & {4{r_power}}};
      default:   w_rd_mux = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= 8'h00;
    end else if (bus.rd_en) begin
      r_rd_data <= w_rd_mux;
    end
  end

  vol_ramp u_ramp_l (
    .clk    (clk),
    .rst    (rst),
    .i_tick (w_tick),
    .i_hold (w_hold),
    .i_tgt  (w_tgt_l),
    .o_cur  (w_cur_l)
  );

  vol_ramp u_ramp_r (
    .clk    (clk),
    .rst    (rst),
    .i_tick (w_tick),
    .i_hold (w_hold),
    .i_tgt  (w_tgt_r),
    .o_cur  (w_cur_r)
  );

  assign bus.rd_data = r_rd_data;
  assign bus.enL     = (r_state == ST_OFF) ? 4'b0000 : {r_nr51[4], r_nr51[5], r_nr51[6], r_nr51[7]};
  assign bus.enR     = (r_state == ST_OFF) ? 4'b0000 : {r_nr51[0], r_nr51[1], r_nr51[2], r_nr51[3]};
  assign bus.volL    = w_cur_l;
  assign bus.volR    = w_cur_r;
  assign bus.busy    = (r_state == ST_FADE_OUT);
endmodule

// File: tb/tb_mixer_ctrl.sv
// tb/tb_mixer_ctrl.sv - self-checking bench for mixer_ctrl with reference model and vector table
module tb_mixer_ctrl;
  localparam int RD = 64;
  localparam int M_OFF = 0, M_ON = 1, M_FADE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mixer_ctrl_if bus ();

  mixer_ctrl #(.RAMP_DIV(RD), .PW(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  int         m_state, m_cl, m_cr, m_cnt;
  logic [7:0] m_nr50, m_nr51, m_rd;
  logic       m_pw;

  typedef struct {
    bit         we;
    bit         re;
    logic [1:0] a;
    logic [7:0] d;
    logic [3:0] ch;
    bit         chk_rd;
    logic [7:0] exp_rd;
    bit         chk_en;
    logic [7:0] exp_en;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a, input logic [3:0] ch);
    case (a)
      2'd0:    return m_nr50;
      2'd1:    return m_nr51;
      2'd2:    return {m_pw, 3'b111, ch & {4{m_pw}}};
      default: return 8'hFF;
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_OFF; m_cl = 0; m_cr = 0; m_cnt = 0;
    m_nr50 = 8'h00; m_nr51 = 8'h00; m_rd = 8'h00; m_pw = 1'b0;
  endtask

  task automatic model_clock(input bit we, input bit re, input logic [1:0] a,
                             input logic [7:0] d, input logic [3:0] ch);
    bit tick;
    tick  = (m_cnt == RD - 1);
    m_cnt = (m_cnt + 1) % RD;
    if (re) m_rd = m_read(a, ch);
    case (m_state)
      M_OFF: begin
        if (we && a == 2'd2 && d[7]) begin
          m_state = M_ON;
          m_pw = 1'b1;
        end
      end
      M_ON: begin
        if (tick) begin
          m_cl = toward(m_cl, int'(m_nr50[6:4]));
          m_cr = toward(m_cr, int'(m_nr50[2:0]));
        end
        if (we && a == 2'd0) m_nr50 = d;
        if (we && a == 2'd1) m_nr51 = d;
        if (we && a == 2'd2 && !d[7]) m_state = M_FADE;
      end
      default: begin
        if (tick) begin
          if (m_cl == 0 && m_cr == 0) begin
            m_state = M_OFF;
            m_nr50 = 8'h00; m_nr51 = 8'h00; m_pw = 1'b0;
          end else begin
            m_cl = toward(m_cl, 0);
            m_cr = toward(m_cr, 0);
          end
        end
      end
    endcase
  endtask

  function automatic logic [22:0] m_outputs();
    logic [3:0] el, er;
    el = 4'b0000; er = 4'b0000;
    if (m_state != M_OFF) begin
      for (int i = 0; i < 4; i++) begin
        el[3 - i] = m_nr51[4 + i];
        er[3 - i] = m_nr51[i];
      end
    end
    return {m_rd, el, er, 3'(m_cl), 3'(m_cr), (m_state == M_FADE)};
  endfunction

  function automatic logic [22:0] dut_outputs();
    return {bus.rd_data, bus.enL, bus.enR, bus.volL, bus.volR, bus.busy};
  endfunction

  task automatic cyc(input bit we, input bit re, input logic [1:0] a,
                     input logic [7:0] d, input logic [3:0] ch);
    bus.wr_en = we; bus.rd_en = re; bus.addr = a; bus.wr_data = d; bus.ch_on = ch;
    @(posedge clk);
    model_clock(we, re, a, d, ch);
    @(negedge clk);
    check("model", 32'(dut_outputs()), 32'(m_outputs()));
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 2'd0, 8'h00, bus.ch_on);
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 2'd0; bus.wr_data = 8'h00; bus.ch_on = 4'h0;
    model_reset();
    #1;
    check("reset_outputs", 32'(dut_outputs()), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    tbl[0] = '{1'b0, 1'b1, 2'd0, 8'h00, 4'hF, 1'b1, 8'h00, 1'b1, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 2'd1, 8'h00, 4'hF, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 2'd2, 8'h00, 4'hF, 1'b1, 8'h70, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 2'd3, 8'h00, 4'hF, 1'b1, 8'hFF, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 2'd2, 8'h80, 4'hF, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 2'd0, 8'h73, 4'hF, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 1'b0, 2'd1, 8'h81, 4'hF, 1'b0, 8'h00, 1'b1, 8'h18};
    tbl[7] = '{1'b0, 1'b1, 2'd2, 8'h00, 4'h5, 1'b1, 8'hF5, 1'b0, 8'h00};

    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].d, tbl[i].ch);
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rd", i), 32'(bus.rd_data), 32'(tbl[i].exp_rd));
      if (tbl[i].chk_en) check($sformatf("tbl%0d_en", i), 32'({bus.enL, bus.enR}), 32'(tbl[i].exp_en));
    end

    idle(8 * RD);
    check("climb_volL", 32'(bus.volL), 32'd7);
    check("climb_volR", 32'(bus.volR), 32'd3);

    cyc(1'b1, 1'b0, 2'd2, 8'h00, 4'h5);
    check("fade_busy", 32'(bus.busy), 32'd1);
    cyc(1'b1, 1'b0, 2'd0, 8'h11, 4'h5);
    for (int n = 0; n < 12 * RD && bus.busy; n++) idle(1);
    check("fade_done", 32'(bus.busy), 32'd0);
    check("off_enables", 32'({bus.enL, bus.enR}), 32'd0);
    cyc(1'b0, 1'b1, 2'd0, 8'h00, 4'h5);
    check("off_nr50", 32'(bus.rd_data), 32'h00);
    cyc(1'b0, 1'b1, 2'd1, 8'h00, 4'h5);
    check("off_nr51", 32'(bus.rd_data), 32'h00);
    cyc(1'b0, 1'b1, 2'd2, 8'h00, 4'h5);
    check("off_nr52", 32'(bus.rd_data), 32'h70);

    cyc(1'b1, 1'b0, 2'd1, 8'hFF, 4'h5);
    cyc(1'b0, 1'b1, 2'd1, 8'h00, 4'h5);
    check("off_wr_ignored", 32'(bus.rd_data), 32'h00);

    cyc(1'b1, 1'b0, 2'd2, 8'h80, 4'h5);
    cyc(1'b1, 1'b0, 2'd0, 8'h73, 4'h5);
    cyc(1'b1, 1'b1, 2'd0, 8'h25, 4'h5);
    check("rdwr_old", 32'(bus.rd_data), 32'h73);
    cyc(1'b0, 1'b1, 2'd0, 8'h00, 4'h5);
    check("rdwr_new", 32'(bus.rd_data), 32'h25);

    cyc(1'b1, 1'b0, 2'd0, 8'h77, 4'h5);
    for (int n = 0; n < 10 * RD && bus.volL != 3'd7; n++) idle(1);
    check("pre_fade_volL", 32'(bus.volL), 32'd7);
    cyc(1'b1, 1'b0, 2'd2, 8'h00, 4'h5);
    for (int n = 0; n < 10 * RD && bus.volL != 3'd4; n++) idle(1);
    check("mid_fade_volL", 32'(bus.volL), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("async_reset", 32'(dut_outputs()), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    cyc(1'b1, 1'b0, 2'd2, 8'h80, 4'h5);
    cyc(1'b1, 1'b0, 2'd0, 8'h70, 4'h5);
    idle(RD - 3);
    check("presc_restart_before", 32'(bus.volL), 32'd0);
    idle(1);
    check("presc_restart_tick", 32'(bus.volL), 32'd1);

    for (int n = 0; n < 4000; n++) begin
      logic [1:0] ra;
      logic [7:0] rdat;
      ra   = 2'($urandom_range(0, 3));
      rdat = 8'($urandom);
      cyc(($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)), ra, rdat, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mixer_ctrl.md
Name: mixer_ctrl

Overview:
- Register front-end and sequencer for the stereo output mixer.
- Holds the master-volume (NR50), panning (NR51) and master-power (NR52) registers written by the CPU bus.
- Drives the mixer's enL/enR/volL/volR inputs.
- Ramps volume one step at a time to avoid clicks, and runs a fade-out sequence before master power-off clears state.

Parameters:
- RAMP_DIV, 64, clock cycles per volume ramp step (>=2).
- PW, 7, prescaler counter width (must satisfy 2^PW >= RAMP_DIV).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  register write strobe, one cycle
- rd_en  input  1  register read strobe, one cycle
- addr  input  2  0=NR50, 1=NR51, 2=NR52, 3=unmapped
- wr_data  input  8  write data
- rd_data  output  8  registered read data
- ch_on  input  4  channel-active flags: [0]=sq1 [1]=sq2 [2]=wave [3]=noise
- enL  output  4  left enables to mixer: [0]=noise [1]=wave [2]=sq2 [3]=sq1
- enR  output  4  right enables, same ordering
- volL  output  3  current left volume
- volR  output  3  current right volume
- busy  output  1  high while in FADE_OUT

Behaviour:
- Reset, asynchronous, active-high. All registers are 0, state=OFF, prescaler=0. All outputs are 0.
- Storage:
  - nr50[7:0]: target left volume tgtL=nr50[6:4], target right volume tgtR=nr50[2:0]. Bits 7 and 3 are stored but unused.
  - nr51[7:0].
  - power bit.
  - curL, curR (3 bits each).
- Panning map, applied combinationally from nr51 in ON and FADE_OUT:
  - enL = {nr51[4], nr51[5], nr51[6], nr51[7]}
  - enR = {nr51[0], nr51[1], nr51[2], nr51[3]}
  - In OFF, enL = enR = 0.
- volL=curL, volR=curR. The mixer gain is vol+1, so muting is done only by the enables.
- Prescaler:
  - Free-running, counts 0..RAMP_DIV-1 and wraps.
  - tick=1 in the cycle where the count equals RAMP_DIV-1.
- Ramp: on each tick, curL moves 1 toward its target; equal means no change. curR behaves the same, independently. Targets are:
  - ON: tgtL, tgtR.
  - FADE_OUT: 0, 0.
  - OFF: curL and curR are held at 0.
- State machine:
  - OFF -> ON: on a write to NR52 with wr_data[7]=1. Sets power=1. cur starts at 0 and ramps up once NR50 is written.
  - ON -> FADE_OUT: on a write to NR52 with wr_data[7]=0. power is still reported as 1 until OFF is reached.
  - FADE_OUT -> OFF: on a tick where curL==0 and curR==0, evaluated before that tick's decrement. On entry to OFF, nr50, nr51 and power are cleared.
  - ON, write to NR52 with bit7=1: no effect.
- Write rules:
  - OFF: writes to NR50/NR51 are ignored.
  - FADE_OUT: all writes are ignored, including NR52.
  - ON: NR50/NR51 writes take effect the next cycle.
  - NR52 bits 6:0 are never stored.
  - addr=3 writes are ignored.
- Read, 1-cycle latency: rd_data updates on the clock edge after rd_en and holds until the next rd_en.
  - addr 0: nr50.
  - addr 1: nr51.
  - addr 2: {power, 3'b111, ch_on[3:0] & {4{power}}}.
  - addr 3: 8'hFF.
- Simultaneous rd_en and wr_en to the same address: the read returns the pre-write value.
- Reset mid-fade or mid-ramp: immediate return to the reset state.

Decomposition:
- Shared package holds:
  - Address constants ADDR_NR50/NR51/NR52.
  - State encoding OFF=0, ON=1, FADE_OUT=2.
  - The NR52 read-pad constant 3'b111.
- One sub-module, vol_ramp: one 3-bit up/down stepper with target and tick inputs, instantiated twice (left and right).
- Prescaler and FSM stay in mixer_ctrl.

Test Plan:
- Reset, then read each address -> rd_data 8'h00, 8'h00, 8'h70, 8'hFF; all mixer outputs 0.
- Write NR52=8'h80, then NR50=8'h73 -> curL climbs 0..7 and curR 0..3, one step per 64 cycles; curR settles after 3 ticks, curL after 7.
- Write NR51=8'h81 in ON -> next cycle enL=4'b0001 (noise), enR=4'b1000 (sq1). Read NR52 with ch_on=4'b0101 -> 8'hF5.
- From ON with cur=7/3, write NR52=8'h00 -> busy=1. Write NR50=8'h11 during the fade is ignored. vol ramps to 0; OFF is reached on the first tick with both at 0. Then busy=0 and enables=0; NR50 and NR51 read 8'h00, NR52 reads 8'h70.
- While OFF, write NR51=8'hFF -> read returns 8'h00. Same-cycle rd/wr to NR50 in ON -> old value returned, new value visible on the next read.
- Assert rst mid-fade (cur=4) -> outputs 0 immediately (asynchronous), state OFF; subsequent tick timing restarts from prescaler 0.
